// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, common-anode seven-segment scanner with per-frame digit snapshot.
// Optional digit blinking is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_bcd,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]               r_presc;
    logic [IW-1:0]               r_idx;
    logic                        r_armed;
    logic [4*NUM_DIGITS-5:0]     r_snap_bcd;
    logic [NUM_DIGITS-1:1]       r_snap_dp;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [7:0]                  r_seg;

    logic                        w_slot_end;
    logic [IW-1:0]               w_idx_next;
    logic [3:0]                  w_new_digit;
    logic                        w_new_dp;
    logic [NUM_DIGITS-1:0]       w_an_lit;
    logic                        w_blank;

    // Active-low segment pattern, bits g..a; non-decimal codes show a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] i_d);
        logic [6:0] v;
        case (i_d)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = 7'h3F;
        endcase
        return v;
    endfunction

    assign w_slot_end = (r_presc == PRESC_LAST);
    assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_an_lit   = ~(NUM_DIGITS'(1) << r_idx);

    // Digit 0 starts a new frame, so it decodes the same live values the snapshot captures.
    always_comb begin
        w_new_digit = i_bcd[3:0];
        w_new_dp    = i_dp[0];
        if (w_idx_next != '0) begin
            w_new_digit = r_snap_bcd[4*(int'(w_idx_next)-1) +: 4];
            w_new_dp    = r_snap_dp[int'(w_idx_next)];
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = r_phase & i_blink[r_idx];
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic w_unused_blink;

    assign w_unused_blink = ^i_blink;
    assign w_blank        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_armed    <= 1'b0;
            r_snap_bcd <= '0;
            r_snap_dp  <= '0;
            r_an       <= '1;
            r_seg      <= 8'hFF;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            if (w_slot_end) begin
                // Slot boundary: blank anodes for one cycle while the new pattern settles.
                r_idx   <= w_idx_next;
                r_armed <= 1'b1;
                r_an    <= '1;
                r_seg   <= {~w_new_dp, f_decode(w_new_digit)};
                if (w_idx_next == '0) begin
                    r_snap_bcd <= i_bcd[4*NUM_DIGITS-1:4];
                    r_snap_dp  <= i_dp[NUM_DIGITS-1:1];
                end
            end else if (r_presc == '0 && r_armed) begin
                // The lit/blank decision is taken once and held for the rest of the slot.
                r_an <= w_blank ? '1 : w_an_lit;
            end
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected {o_an, o_seg} per cycle are queued
// alongside the stimulus and popped one per clock.
module tb_seg7_scan_driver;

    localparam int ND = 3;
    localparam int RD = 4;
    localparam int BD = 16;
    localparam int W  = ND + 8;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [4*ND-1:0] i_bcd;
    logic [ND-1:0]   i_dp;
    logic [ND-1:0]   i_blink;
    logic [7:0]      o_seg;
    logic [ND-1:0]   o_an;

    always #5 i_clk = ~i_clk;

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_bcd  (i_bcd),
        .i_dp   (i_dp),
        .i_blink(i_blink),
        .o_seg  (o_seg),
        .o_an   (o_an)
    );

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           slot_m   = 0;
    string        tag      = "init";

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back({{ND{1'b1}}, 8'hFF});
    endtask

    // One slot: a blank cycle with the new pattern, then RD-1 lit cycles.
    task automatic push_slot(input int idx, input logic [7:0] seg);
        logic [ND-1:0] an;
        logic          blank;
        slot_m++;
        blank = 1'b0;
`ifdef SEG7_BLINK_EN
        blank = i_blink[idx] && ((((RD * slot_m) / BD) % 2) == 1);
`endif
        an = '1;
        if (!blank) an[idx] = 1'b0;
        exp_q.push_back({{ND{1'b1}}, seg});
        repeat (RD - 1) exp_q.push_back({an, seg});
    endtask

    task automatic check_n(input int n);
        logic [W-1:0] obs;
        logic [W-1:0] e_val;
        repeat (n) begin
            @(posedge i_clk);
            #1;
            obs = {o_an, o_seg};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $error("FAIL %s: no expectation queued, observed an=%b seg=%h", tag, obs[W-1:8], obs[7:0]);
            end else begin
                e_val = exp_q.pop_front();
                assert (obs === e_val) else begin
                    n_errors++;
                    $error("FAIL %s: observed an=%b seg=%h, expected an=%b seg=%h",
                           tag, obs[W-1:8], obs[7:0], e_val[W-1:8], e_val[7:0]);
                end
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_bcd   = 12'h159;
        i_dp    = 3'b000;
        i_blink = 3'b000;

        tag = "reset";
        push_idle(3);
        check_n(3);

        i_reset = 1'b0;
        slot_m  = 0;
        tag = "first_frame";
        push_idle(3);
        check_n(3);
        push_slot(1, 8'hC0);
        push_slot(2, 8'hC0);
        check_n(8);
        push_slot(0, 8'h90);
        check_n(4);

        tag = "snapshot_hold";
        push_slot(1, 8'h92);
        check_n(2);
        i_bcd = 12'h200;
        check_n(2);
        push_slot(2, 8'hF9);
        check_n(4);

        tag = "new_frame";
        push_slot(0, 8'hC0);
        push_slot(1, 8'hC0);
        check_n(8);
        push_slot(2, 8'hA4);
        check_n(2);
        i_bcd = 12'h0A0;
        check_n(2);

        tag = "dash";
        push_slot(0, 8'hC0);
        push_slot(1, 8'hBF);
        check_n(8);
        push_slot(2, 8'hC0);
        check_n(2);
        i_bcd = 12'h888;
        i_dp  = 3'b010;
        check_n(2);

        tag = "decimal_point";
        push_slot(0, 8'h80);
        push_slot(1, 8'h00);
        check_n(8);

        tag = "mid_slot_reset";
        push_slot(2, 8'h80);
        check_n(2);
        i_reset = 1'b1;
        exp_q.delete();
        push_idle(1);
        check_n(1);

        i_reset = 1'b0;
        i_blink = 3'b001;
        slot_m  = 0;
        tag = "restart";
        push_idle(3);
        check_n(3);
        push_slot(1, 8'hC0);
        push_slot(2, 8'hC0);
        check_n(8);

        tag = "blink_mask";
        for (int f = 0; f < 4; f++) begin
            push_slot(0, 8'h80);
            push_slot(1, 8'h00);
            push_slot(2, 8'h80);
            check_n(12);
        end

        tag = "drain";
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL %s: observed %0d leftover expectations, expected 0", tag, exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
